// File: rtl/forth_pkg.sv
// Shared types and constants for the Forth CPU stack blocks.
package forth_pkg;

  typedef enum logic [1:0] {
    DELTA_NONE = 2'b00,
    DELTA_PUSH = 2'b01,
    DELTA_RSVD = 2'b10,
    DELTA_POP  = 2'b11
  } stack_delta_e;

  // Overflow/underflow policy selected by the stack's TRAP parameter
  localparam bit MODE_WRAP = 1'b0;
  localparam bit MODE_TRAP = 1'b1;

endpackage

// File: rtl/forth_stack_if.sv
// CPU-to-stack bundle: SP control, write port, peek port, status and error flags.
interface forth_stack_if
  import forth_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned AW = $clog2(DEPTH);

  stack_delta_e     delta;
  logic             we;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic [AW-1:0]    peek_idx;
  logic [WIDTH-1:0] peek_data;
  logic [AW-1:0]    sp;
  logic [AW:0]      depth;
  logic             full;
  logic             empty;
  logic [AW:0]      hwm;
  logic             hwm_clr;
  logic             overflow;
  logic             underflow;
  logic             err_clr;

  modport master (
    output delta, we, wdata, peek_idx, hwm_clr, err_clr,
    input  rdata, peek_data, sp, depth, full, empty, hwm, overflow, underflow
  );

  modport slave (
    input  delta, we, wdata, peek_idx, hwm_clr, err_clr,
    output rdata, peek_data, sp, depth, full, empty, hwm, overflow, underflow
  );

endinterface

// File: rtl/forth_stack_ram.sv
// Stack storage: one synchronous write port, two asynchronous read ports.
module forth_stack_ram #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata,
  input  logic [AW-1:0]    paddr,
  output logic [WIDTH-1:0] pdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
  assign pdata = mem[paddr];

endmodule

// File: rtl/forth_stack.sv
// Forth CPU hardware stack (NOS and below): pointer, count, sticky errors, high-water mark.
module forth_stack
  import forth_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16,
  parameter bit          TRAP  = MODE_WRAP
) (
  input logic          clk,
  input logic          reset,
  forth_stack_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0] sp_q, sp_n;
  logic [AW:0]   depth_q, depth_n;
  logic [AW:0]   hwm_q, hwm_n;
  logic          ovf_q, unf_q;
  logic          ovf_set, unf_set;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          is_full, is_empty;

  assign is_full  = (depth_q == (AW+1)'(DEPTH));
  assign is_empty = (depth_q == '0);

  // Next pointer/count, write request and error detection for this cycle's op
  always_comb begin
    sp_n    = sp_q;
    depth_n = depth_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    wr_en   = 1'b0;
    wr_addr = sp_q;
    case (bus.delta)
      DELTA_NONE: wr_en = bus.we;
      DELTA_PUSH: begin
        wr_addr = sp_q + AW'(1);
        if (is_full) begin
          ovf_set = 1'b1;
          if (TRAP == MODE_WRAP) begin
            sp_n  = sp_q + AW'(1);
            wr_en = bus.we;
          end
        end else begin
          sp_n    = sp_q + AW'(1);
          depth_n = depth_q + (AW+1)'(1);
          wr_en   = bus.we;
        end
      end
      DELTA_POP: begin
        if (is_empty) begin
          unf_set = 1'b1;
          if (TRAP == MODE_WRAP) sp_n = sp_q - AW'(1);
        end else begin
          sp_n    = sp_q - AW'(1);
          depth_n = depth_q - (AW+1)'(1);
        end
      end
      default: ;
    endcase
    if (bus.hwm_clr || (depth_n > hwm_q)) hwm_n = depth_n;
    else                                  hwm_n = hwm_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q    <= '0;
      depth_q <= '0;
      hwm_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      sp_q    <= sp_n;
      depth_q <= depth_n;
      hwm_q   <= hwm_n;
      // A new error in the same cycle as err_clr leaves the flag set
      ovf_q   <= ovf_set | (ovf_q & ~bus.err_clr);
      unf_q   <= unf_set | (unf_q & ~bus.err_clr);
    end
  end

  forth_stack_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en & ~reset),
    .waddr (wr_addr),
    .wdata (bus.wdata),
    .raddr (sp_q),
    .rdata (bus.rdata),
    .paddr (sp_q - bus.peek_idx),
    .pdata (bus.peek_data)
  );

  assign bus.sp        = sp_q;
  assign bus.depth     = depth_q;
  assign bus.full      = is_full;
  assign bus.empty     = is_empty;
  assign bus.hwm       = hwm_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;

endmodule
